// File: rtl/coo_aggregation_ctrl.sv
// Aggregation + argmax sequencer for the GCN: walks the COO edge list, accumulates
// (A+I)*FM_WM rows into a per-node bank, then latches a per-node argmax class index.
module coo_aggregation_ctrl #(
  parameter int NUM_OF_NODES      = 6,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_NUM_OF_ROWS   = 2,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int MAX_ADDRESS_WIDTH = 2,
  parameter int ROW_BW            = $clog2(NUM_OF_NODES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [COO_BW-1:0]            coo_in          [0:COO_NUM_OF_ROWS-1],
  input  logic [DOT_PROD_WIDTH-1:0]    FM_WM_ROW       [0:WEIGHT_COLS-1],
  output logic [COO_BW-1:0]            coo_address,
  output logic [ROW_BW-1:0]            read_fm_wm_row,
  output logic                         busy,
  output logic                         done,
  output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:NUM_OF_NODES-1]
);

  typedef enum logic [2:0] {IDLE, SELF, EDGE_A, EDGE_B, ARGMAX, DONE} state_t;

  localparam logic [ROW_BW-1:0] LAST_NODE = ROW_BW'(NUM_OF_NODES - 1);
  localparam logic [COO_BW-1:0] LAST_EDGE = COO_BW'(COO_NUM_OF_COLS - 1);

  state_t                         state, state_next;
  logic                           start_q;
  logic                           launch;
  logic [ROW_BW-1:0]              node_cnt;
  logic [ROW_BW-1:0]              row_q;
  logic                           edge_ok;
  logic                           acc_en, acc_load;
  logic [COO_BW-1:0]              acc_node;
  logic [DOT_PROD_WIDTH-1:0]      acc    [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
  logic [MAX_ADDRESS_WIDTH-1:0]   argmax [0:NUM_OF_NODES-1];
  logic [MAX_ADDRESS_WIDTH-1:0]   best;

  function automatic logic in_range(input logic [COO_BW-1:0] idx);
    return 32'(idx) < 32'(NUM_OF_NODES);
  endfunction

  assign edge_ok = in_range(coo_in[0]) && in_range(coo_in[1]);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE:    if (start) begin
                 state_next = SELF;
                 launch     = 1'b1;
               end
      SELF:    if (node_cnt == LAST_NODE) state_next = EDGE_A;
      EDGE_A:  state_next = EDGE_B;
      EDGE_B:  state_next = (coo_address == LAST_EDGE) ? ARGMAX : EDGE_A;
      ARGMAX:  state_next = DONE;
      DONE:    if (start && !start_q) begin
                 state_next = SELF;
                 launch     = 1'b1;
               end
      default: state_next = IDLE;
    endcase
  end

  // Row select in the edge phases follows coo_in in the same cycle so the FM_WM
  // row arrives in time to accumulate; outside busy states it holds the last value.
  always_comb begin
    acc_en         = 1'b0;
    acc_load       = 1'b0;
    acc_node       = '0;
    read_fm_wm_row = row_q;
    case (state)
      SELF: begin
        read_fm_wm_row = node_cnt;
        acc_en         = 1'b1;
        acc_load       = 1'b1;
        acc_node       = COO_BW'(node_cnt);
      end
      EDGE_A: begin
        read_fm_wm_row = edge_ok ? ROW_BW'(coo_in[1]) : '0;
        acc_en         = edge_ok;
        acc_node       = coo_in[0];
      end
      EDGE_B: begin
        read_fm_wm_row = edge_ok ? ROW_BW'(coo_in[0]) : '0;
        acc_en         = edge_ok;
        acc_node       = coo_in[1];
      end
      default: ;
    endcase
  end

  // Strict greater-than keeps the lowest column index on ties.
  always_comb begin
    best = '0;
    for (int unsigned n = 0; n < NUM_OF_NODES; n++) begin
      best = '0;
      for (int unsigned k = 1; k < WEIGHT_COLS; k++) begin
        if (acc[n][k] > acc[n][best]) best = MAX_ADDRESS_WIDTH'(k);
      end
      argmax[n] = best;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q     <= 1'b0;
      node_cnt    <= '0;
      row_q       <= '0;
      coo_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int unsigned n = 0; n < NUM_OF_NODES; n++) begin
        max_addi_answer[n] <= '0;
        for (int unsigned k = 0; k < WEIGHT_COLS; k++) acc[n][k] <= '0;
      end
    end else begin
      start_q <= start;
      row_q   <= read_fm_wm_row;
      busy    <= (state != IDLE) && (state != DONE);
      done    <= (state == DONE) && !launch;

      if (launch)               node_cnt <= '0;
      else if (state == SELF)   node_cnt <= node_cnt + 1'b1;

      if (launch)
        coo_address <= '0;
      else if (state == EDGE_B && coo_address != LAST_EDGE)
        coo_address <= coo_address + 1'b1;

      if (acc_en) begin
        for (int unsigned k = 0; k < WEIGHT_COLS; k++)
          acc[acc_node][k] <= acc_load ? FM_WM_ROW[k] : acc[acc_node][k] + FM_WM_ROW[k];
      end

      if (state == ARGMAX) begin
        for (int unsigned n = 0; n < NUM_OF_NODES; n++) max_addi_answer[n] <= argmax[n];
      end
    end
  end

endmodule

// File: tb/tb_coo_aggregation_ctrl.sv
// Scoreboard bench for coo_aggregation_ctrl: a behavioural (A+I)*FM_WM + argmax model
// pushes expected answers at start; they are popped and compared when done rises.
module tb_coo_aggregation_ctrl;

  logic        clk, reset, start;
  logic [2:0]  coo_in [0:1];
  logic [15:0] fm_row [0:2];
  logic [2:0]  coo_address;
  logic [2:0]  read_fm_wm_row;
  logic        busy, done;
  logic [1:0]  answer [0:5];

  logic [2:0]  src_t [0:7];
  logic [2:0]  dst_t [0:7];
  logic [15:0] fm_t  [0:7][0:2];

  logic [11:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  coo_aggregation_ctrl #(
    .NUM_OF_NODES(6), .COO_NUM_OF_COLS(6), .COO_NUM_OF_ROWS(2),
    .WEIGHT_COLS(3), .DOT_PROD_WIDTH(16), .MAX_ADDRESS_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .coo_in(coo_in), .FM_WM_ROW(fm_row),
    .coo_address(coo_address), .read_fm_wm_row(read_fm_wm_row),
    .busy(busy), .done(done), .max_addi_answer(answer)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memories answer combinationally; rows 6/7 hold junk that must never be summed.
  always_comb begin
    coo_in[0] = src_t[coo_address];
    coo_in[1] = dst_t[coo_address];
    for (int k = 0; k < 3; k++) fm_row[k] = fm_t[read_fm_wm_row][k];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model();
    logic [15:0] a [0:5][0:2];
    logic [11:0] r;
    int unsigned b, s, d;
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 3; k++) a[i][k] = fm_t[i][k];
    for (int e = 0; e < 6; e++) begin
      s = src_t[e];
      d = dst_t[e];
      if (s < 6 && d < 6)
        for (int k = 0; k < 3; k++) begin
          a[s][k] = a[s][k] + fm_t[d][k];
          a[d][k] = a[d][k] + fm_t[s][k];
        end
    end
    r = '0;
    for (int n = 0; n < 6; n++) begin
      b = 0;
      for (int k = 1; k < 3; k++) if (a[n][k] > a[n][b]) b = k;
      r[2*n +: 2] = 2'(b);
    end
    return r;
  endfunction

  task automatic clear_tables();
    for (int i = 0; i < 8; i++) begin
      src_t[i] = 3'd0;
      dst_t[i] = 3'd0;
      for (int k = 0; k < 3; k++) fm_t[i][k] = (i >= 6) ? 16'd999 : 16'd0;
    end
  endtask

  task automatic set_ring();
    for (int e = 0; e < 6; e++) begin
      src_t[e] = 3'(e);
      dst_t[e] = 3'((e + 1) % 6);
    end
  endtask

  task automatic run_job(input bit hold, input string tag);
    int lat, bcnt, badrow;
    logic [11:0] exp;
    exp_q.push_back(model());
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!hold) start = 1'b0;
    lat = 0; bcnt = 0; badrow = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (read_fm_wm_row >= 3'd6) badrow++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check($sformatf("%s_latency", tag), 64'(lat), 64'd20);
    check($sformatf("%s_busy_cycles", tag), 64'(bcnt), 64'd19);
    check($sformatf("%s_row_range", tag), 64'(badrow), 64'd0);
    exp = exp_q.pop_front();
    for (int n = 0; n < 6; n++)
      check($sformatf("%s_answer%0d", tag, n), 64'(answer[n]), 64'(exp[2*n +: 2]));
  endtask

  initial begin
    logic [1:0] ans_or;
    reset = 1'b1;
    start = 1'b0;
    clear_tables();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      ans_or = '0;
      for (int n = 0; n < 6; n++) ans_or = ans_or | answer[n];
      check("idle_quiet", {busy, done, coo_address, read_fm_wm_row, ans_or}, 64'd0);
    end

    clear_tables(); set_ring();
    for (int n = 0; n < 6; n++) fm_t[n][0] = 16'(n);
    run_job(1'b0, "ring");

    // All self-edges on node 0; start held high through DONE must not retrigger.
    clear_tables();
    for (int n = 0; n < 6; n++) fm_t[n][n % 3] = 16'd7;
    run_job(1'b1, "selfedge");
    repeat (10) @(posedge clk);
    #1;
    check("hold_no_restart_done", 64'(done), 64'd1);
    check("hold_no_restart_busy", 64'(busy), 64'd0);
    @(negedge clk); start = 1'b0;

    clear_tables(); set_ring();
    for (int n = 0; n < 6; n++)
      for (int k = 0; k < 3; k++) fm_t[n][k] = 16'd5;
    run_job(1'b0, "tie");

    clear_tables();
    fm_t[0][0] = 16'hFFFF; fm_t[0][1] = 16'd1;
    fm_t[1][0] = 16'd1;
    for (int n = 2; n < 6; n++) fm_t[n][2] = 16'd2;
    for (int e = 0; e < 6; e++) begin
      src_t[e] = 3'd0;
      dst_t[e] = 3'(e == 0 ? 1 : e);
    end
    run_job(1'b0, "wrap");

    for (int r = 0; r < 3; r++) begin
      clear_tables();
      for (int n = 0; n < 6; n++)
        for (int k = 0; k < 3; k++) fm_t[n][k] = 16'($urandom);
      for (int e = 0; e < 6; e++) begin
        src_t[e] = 3'($urandom_range(0, 5));
        dst_t[e] = 3'($urandom_range(0, 5));
      end
      run_job(1'b0, $sformatf("rand%0d", r));
    end

    clear_tables(); set_ring();
    src_t[1] = 3'd7;
    for (int n = 0; n < 6; n++) fm_t[n][n % 3] = 16'(10 * (n + 1));
    run_job(1'b0, "oob");

    // Abort mid-run with reset sampled at edge t+9.
    clear_tables();
    for (int n = 0; n < 6; n++) fm_t[n][n % 3] = 16'd7;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    ans_or = '0;
    for (int n = 0; n < 6; n++) ans_or = ans_or | answer[n];
    check("rst_answers", 64'(ans_or), 64'd0);
    for (int n = 0; n < 6; n++)
      for (int k = 0; k < 3; k++)
        check($sformatf("rst_acc%0d_%0d", n, k), 64'(dut.acc[n][k]), 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stays_idle", {busy, done, coo_address, read_fm_wm_row}, 64'd0);
    run_job(1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
